i2c_master_controller: RTL
==========================

Name: i2c_master_controller

Overview:
Byte-level I2C initiator. Generates START, repeated START, STOP, 8-bit write and 8-bit read transfers on open-drain SCL/SDA lines from single-cycle commands issued by a bus wrapper/CPU interface. It is the initiator counterpart to the team's I2C slave controller and drives the same two-wire bus.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
I2C_FREQ, 100_000, SCL frequency in Hz.
DVSR, CLK_FREQ/(4*I2C_FREQ), clk cycles per SCL quarter-period (default 250). Must be >= 4; elaboration error otherwise.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-low
i_cmd  input  3  command: 000 START, 001 WRITE, 010 READ, 011 STOP, 100 RESTART; other codes ignored
i_cmd_valid  input  1  command strobe, sampled only when o_ready=1
i_data  input  8  WRITE: byte to send; READ: i_data[0] is the ACK bit to return (0=ACK, 1=NACK)
o_data  output  8  last byte read
o_ack  output  1  ACK sampled on 9th bit of last transfer (0=ACK, 1=NACK)
o_ready  output  1  controller can accept a command
o_done_tick  output  1  one-cycle pulse at end of each WRITE/READ
o_busy  output  1  bus owned (between START and completion of STOP)
scl  inout  1  open-drain SCL (drives 0 or Z)
sda  inout  1  open-drain SDA (drives 0 or Z)

Behaviour:
- Reset (async assert): state IDLE, SCL/SDA released (Z) immediately, o_ready=1, o_busy=0, o_data=0, o_ack=0, o_done_tick=0, counters cleared. Reset mid-transfer abandons it with no STOP.
- SDA and SCL inputs double-synchronised before use.
- Quarter counter counts 0..DVSR-1; every phase below is DVSR cycles per quarter.
- States: IDLE, START1, START2, HOLD, DATA1, DATA2, DATA3, DATA4, DATA_END, RESTART, STOP1, STOP2.
- IDLE: lines released, o_ready=1. Only START accepted; all other commands dropped.
- START1: SDA=0, SCL=Z, 2 quarters. START2: SDA=0, SCL=0, 1 quarter -> HOLD. o_busy=1 from START acceptance.
- HOLD: SCL=0, SDA held at last value, o_ready=1. Accepts WRITE, READ, STOP, RESTART; START in HOLD is ignored.
- Acceptance: o_ready falls the cycle after i_cmd_valid sampled high; i_data latched then.
- WRITE/READ: 9 bits, MSB first, 4 quarters each: DATA1 SCL=0 SDA=bit; DATA2 SCL=Z; DATA3 SCL=Z; DATA4 SCL=0. SDA sampled at DATA2->DATA3 transition.
  - WRITE bits 1-8 drive shift register; bit 9 SDA released, sample -> o_ack.
  - READ bits 1-8 SDA released, samples shifted into o_data; bit 9 drives i_data[0]; o_ack = i_data[0].
  - SDA changes only while SCL low.
- DATA_END: SCL=0, 1 quarter; o_done_tick pulses on exit; -> HOLD. o_data/o_ack update no later than the o_done_tick cycle.
- Latency WRITE/READ: accept -> o_done_tick = 37*DVSR cycles (+/-1).
- RESTART: SDA=Z, SCL=0 1 quarter, then SCL=Z 1 quarter, -> START1.
- STOP1: SDA=0, SCL=0 1 quarter, then SCL=Z 1 quarter; STOP2: SDA=Z, SCL=Z, 2 quarters -> IDLE, o_busy=0.
- No arbitration-loss detection; single-master bus.

Optional Feature:
I2C_CLK_STRETCH_EN. Defined: in DATA2, START1, STOP1, STOP2 and RESTART's SCL-high quarter, the quarter counter holds while synchronised SCL reads 0 after release (slave stretching); transfer resumes once SCL high. Undefined: SCL input not observed; timing purely counter-driven, latency fixed.

Test Plan:
DVSR=4; START, WRITE 0x10, responder ACKs -> SDA bits 0,0,0,1,0,0,0,0 on SCL rising edges, o_ack=0, o_done_tick 148 cycles after accept.
WRITE 0x11 then READ with i_data[0]=1, responder returns 0xA5 -> o_data=0xA5, SDA released on 9th bit, o_ack=1.
WRITE 0x22 with no responder (SDA floats high) -> o_ack=1, controller back in HOLD, o_ready=1.
IDLE, issue WRITE/READ/STOP -> no line activity, o_ready stays 1; then START, STOP -> SDA rises while SCL high, o_busy=0.
START, WRITE, RESTART, WRITE -> SDA falls with SCL high before second byte; no STOP between; o_busy stays 1.
Assert reset mid-byte (bit 4) -> SCL/SDA Z same cycle, o_ready=1; with I2C_CLK_STRETCH_EN, responder holds SCL low 20 cycles at bit 3 -> o_done_tick delayed exactly 20 cycles.

Source files
------------

// File: rtl/i2c_master_controller.sv
// Byte-level I2C initiator: START / repeated START / STOP and 8-bit write/read on open-drain SCL/SDA.
// Define I2C_CLK_STRETCH_EN to let a responder stretch SCL high phases; undefined, timing is purely counter-driven.
module i2c_master_controller #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int I2C_FREQ = 100_000,
    parameter int DVSR     = CLK_FREQ / (4 * I2C_FREQ)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_cmd,
    input  logic       i_cmd_valid,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_ack,
    output logic       o_ready,
    output logic       o_done_tick,
    output logic       o_busy,
    inout  wire        scl,
    inout  wire        sda
);
    // Handshake: i_cmd/i_data are taken on a clock edge where i_cmd_valid and o_ready are both high;
    // o_ready drops the next cycle and rises again when the controller can take another command.

    if (DVSR < 4) begin : g_dvsr_check
        $error("i2c_master_controller: DVSR must be >= 4");
    end

    localparam int            QW     = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(DVSR - 1);
    localparam logic [QW-1:0] Q_SYNC = QW'(2);

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WRITE   = 3'b001;
    localparam logic [2:0] CMD_READ    = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    typedef enum logic [3:0] {
        IDLE, START1, START2, HOLD, DATA1, DATA2, DATA3, DATA4,
        DATA_END, RESTART, STOP1, STOP2
    } state_t;

    state_t        state;
    logic [QW-1:0] q_cnt;
    logic          qsec;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          is_read;
    logic          ack_tx;
    logic          ack_rx;
    logic          scl_oe;
    logic          sda_oe;
    logic          sda_s1, sda_s2;
    logic          stall;
    logic          q_end;

    assign scl = scl_oe ? 1'b0 : 1'bz;
    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
        end
    end

`ifdef I2C_CLK_STRETCH_EN
    logic scl_s1, scl_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
        end
    end

    // The first two counts after release cover synchroniser latency, so an unstretched bus never stalls.
    always_comb begin
        stall = 1'b0;
        if (!scl_oe && !scl_s2 && (q_cnt >= Q_SYNC)) begin
            case (state)
                DATA2, START1, STOP2: stall = 1'b1;
                STOP1, RESTART:       stall = qsec;
                default:              stall = 1'b0;
            endcase
        end
    end
`else
    assign stall = 1'b0;
`endif

    assign q_end = (q_cnt == Q_LAST) && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            q_cnt       <= '0;
            qsec        <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            is_read     <= 1'b0;
            ack_tx      <= 1'b0;
            ack_rx      <= 1'b0;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
            o_data      <= '0;
            o_ack       <= 1'b0;
            o_ready     <= 1'b1;
            o_done_tick <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_done_tick <= 1'b0;
            if (state == IDLE || state == HOLD)
                q_cnt <= '0;
            else if (!stall)
                q_cnt <= (q_cnt == Q_LAST) ? '0 : q_cnt + 1'b1;

            case (state)
                IDLE: begin
                    scl_oe  <= 1'b0;
                    sda_oe  <= 1'b0;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                    if (i_cmd_valid && o_ready && i_cmd == CMD_START) begin
                        state   <= START1;
                        qsec    <= 1'b0;
                        sda_oe  <= 1'b1;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                START1: if (q_end) begin
                    qsec <= ~qsec;
                    if (qsec) begin
                        state  <= START2;
                        scl_oe <= 1'b1;
                    end
                end
                START2: if (q_end) begin
                    state   <= HOLD;
                    o_ready <= 1'b1;
                end
                HOLD: if (i_cmd_valid && o_ready) begin
                    qsec    <= 1'b0;
                    bit_cnt <= '0;
                    case (i_cmd)
                        CMD_WRITE: begin
                            state   <= DATA1;
                            shreg   <= i_data;
                            is_read <= 1'b0;
                            sda_oe  <= ~i_data[7];
                            o_ready <= 1'b0;
                        end
                        CMD_READ: begin
                            state   <= DATA1;
                            shreg   <= '0;
                            is_read <= 1'b1;
                            ack_tx  <= i_data[0];
                            sda_oe  <= 1'b0;
                            o_ready <= 1'b0;
                        end
                        CMD_STOP: begin
                            state   <= STOP1;
                            sda_oe  <= 1'b1;
                            o_ready <= 1'b0;
                        end
                        CMD_RESTART: begin
                            state   <= RESTART;
                            sda_oe  <= 1'b0;
                            o_ready <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                DATA1: if (q_end) begin
                    state  <= DATA2;
                    scl_oe <= 1'b0;
                end
                DATA2: if (q_end) begin
                    state <= DATA3;
                    if (bit_cnt == 4'd8)
                        ack_rx <= sda_s2;
                    else if (is_read)
                        shreg <= {shreg[6:0], sda_s2};
                end
                DATA3: if (q_end) begin
                    state  <= DATA4;
                    scl_oe <= 1'b1;
                end
                DATA4: if (q_end) begin
                    if (bit_cnt == 4'd8) begin
                        state <= DATA_END;
                    end else begin
                        state   <= DATA1;
                        bit_cnt <= bit_cnt + 4'd1;
                        // Bit 9 is the acknowledge slot: the reader drives it, the writer releases SDA.
                        if (is_read)
                            sda_oe <= (bit_cnt == 4'd7) ? ~ack_tx : 1'b0;
                        else begin
                            sda_oe <= (bit_cnt == 4'd7) ? 1'b0 : ~shreg[6];
                            shreg  <= {shreg[6:0], 1'b0};
                        end
                    end
                end
                DATA_END: if (q_end) begin
                    state       <= HOLD;
                    o_ready     <= 1'b1;
                    o_done_tick <= 1'b1;
                    if (is_read) begin
                        o_data <= shreg;
                        o_ack  <= ack_tx;
                    end else begin
                        o_ack  <= ack_rx;
                    end
                end
                RESTART: if (q_end) begin
                    qsec <= ~qsec;
                    if (qsec) begin
                        state  <= START1;
                        sda_oe <= 1'b1;
                    end else begin
                        scl_oe <= 1'b0;
                    end
                end
                STOP1: if (q_end) begin
                    qsec <= ~qsec;
                    if (qsec) begin
                        state  <= STOP2;
                        sda_oe <= 1'b0;
                    end else begin
                        scl_oe <= 1'b0;
                    end
                end
                STOP2: if (q_end) begin
                    qsec <= ~qsec;
                    if (qsec) begin
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
